// File: rtl/cnn_pkg.sv
// Shared CNN accelerator types: image geometry, pixel/row/window types, row-scheduler states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: IMG_W/IMG_H/K/DW geometry, pix_t, row_t, win_t, state_t.
package cnn_pkg;

    localparam int IMG_W    = 28;              // pixels per row
    localparam int IMG_H    = 28;              // rows per frame
    localparam int K        = 3;               // kernel height (window rows)
    localparam int DW       = 8;               // pixel width
    localparam int AW       = $clog2(IMG_H);   // row index width
    localparam int KW       = $clog2(K);       // window slot index width
    localparam int LAST_ROW = IMG_H - K;       // output row of the final window

    typedef logic [DW-1:0]    pix_t;
    typedef pix_t [IMG_W-1:0] row_t;
    typedef row_t [K-1:0]     win_t;           // [0] is the top (oldest) row

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        EMIT,
        FETCH,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/im2col_line_buf.sv
// K-row sliding window: on shift_en every slot moves up one and row_in enters the bottom slot.
// Latency: 1 cycle from shift_en to the updated window.
// Backpressure: none; the window holds whenever shift_en is low.
// Ports: i_clk, i_rstn (sync, active-low), shift_en, row_in (new row), win (K rows, [0] oldest).
module im2col_line_buf
    import cnn_pkg::*;
(
    input  logic i_clk,
    input  logic i_rstn,
    input  logic shift_en,
    input  row_t row_in,
    output win_t win
);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            win <= '0;
        end else if (shift_en) begin
            for (int k = 0; k < K - 1; k++) begin
                win[k] <= win[k + 1];
            end
            win[K-1] <= row_in;
        end
    end

endmodule

// File: rtl/im2col_row_sched.sv
// Row scheduler: reads image rows, keeps a K-row window and emits the IMG_H-K+1 windows of a frame.
// Latency: first window 5 cycles after start is sampled, then one window per 3 cycles at full ready.
// Backpressure: window and row index hold while o_win_valid is high and i_win_ready is low.
// Ports: i_start/i_abort control, o_busy/o_done status, o_mem_rd_* row reads with i_mem_rd_data
//        returned one cycle later, o_win_valid/i_win_ready/o_win_data/o_win_row window handshake.
module im2col_row_sched
    import cnn_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_rd_en,
    output logic [AW-1:0] o_mem_rd_addr,
    input  row_t          i_mem_rd_data,
    output logic          o_win_valid,
    input  logic          i_win_ready,
    output win_t          o_win_data,
    output logic [AW-1:0] o_win_row
);

    state_t        state;
    logic          rd_pend;    // read data is on i_mem_rd_data this cycle
    logic [KW-1:0] prime_cnt;  // rows captured so far while priming
    logic          hs;
    logic          shift_en;

    assign hs = o_win_valid & i_win_ready;

    // The window only changes when a read returns in PRIME/WAIT; an abort
    // in the same cycle discards the returning row.
    assign shift_en = rd_pend && !i_abort && (state == PRIME || state == WAIT);

    im2col_line_buf u_line_buf (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .shift_en (shift_en),
        .row_in   (i_mem_rd_data),
        .win      (o_win_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state         <= IDLE;
            rd_pend       <= 1'b0;
            prime_cnt     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_mem_rd_en   <= 1'b0;
            o_mem_rd_addr <= '0;
            o_win_valid   <= 1'b0;
            o_win_row     <= '0;
        end else begin
            rd_pend <= o_mem_rd_en;
            o_done  <= 1'b0;
            if (state != IDLE && i_abort) begin
                // Abort wins over a simultaneous handshake and drops any pending return.
                state       <= IDLE;
                rd_pend     <= 1'b0;
                o_busy      <= 1'b0;
                o_mem_rd_en <= 1'b0;
                o_win_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            state         <= PRIME;
                            o_busy        <= 1'b1;
                            o_mem_rd_en   <= 1'b1;
                            o_mem_rd_addr <= '0;
                            o_win_row     <= '0;
                            prime_cnt     <= '0;
                        end
                    end
                    PRIME: begin
                        // Back-to-back reads of rows 0..K-1.
                        if (o_mem_rd_en) begin
                            if (o_mem_rd_addr == AW'(K - 1)) begin
                                o_mem_rd_en <= 1'b0;
                            end else begin
                                o_mem_rd_addr <= o_mem_rd_addr + 1'b1;
                            end
                        end
                        if (rd_pend) begin
                            if (prime_cnt == KW'(K - 1)) begin
                                state       <= EMIT;
                                o_win_valid <= 1'b1;
                            end else begin
                                prime_cnt <= prime_cnt + 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        if (hs) begin
                            o_win_valid <= 1'b0;
                            if (o_win_row == AW'(LAST_ROW)) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end else begin
                                // Next row needed is (row+1)+K-1 = row+K.
                                state         <= FETCH;
                                o_win_row     <= o_win_row + 1'b1;
                                o_mem_rd_en   <= 1'b1;
                                o_mem_rd_addr <= o_win_row + AW'(K);
                            end
                        end
                    end
                    FETCH: begin
                        o_mem_rd_en <= 1'b0;
                        state       <= WAIT;
                    end
                    WAIT: begin
                        if (rd_pend) begin
                            state       <= EMIT;
                            o_win_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im2col_row_sched.sv
// Self-checking bench for im2col_row_sched: directed scenarios with random ready back-pressure.
// Latency: n/a.
// Backpressure: i_win_ready driven by the scenarios (tied high, random, forced stalls).
module tb_im2col_row_sched;
    import cnn_pkg::*;

    localparam int WINB = $bits(win_t);

    logic          i_clk       = 1'b0;
    logic          i_rstn      = 1'b0;
    logic          i_start     = 1'b0;
    logic          i_abort     = 1'b0;
    logic          i_win_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_rd_addr;
    row_t          i_mem_rd_data;
    logic          o_win_valid;
    win_t          o_win_data;
    logic [AW-1:0] o_win_row;

    im2col_row_sched dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_mem_rd_en   (o_mem_rd_en),
        .o_mem_rd_addr (o_mem_rd_addr),
        .i_mem_rd_data (i_mem_rd_data),
        .o_win_valid   (o_win_valid),
        .i_win_ready   (i_win_ready),
        .o_win_data    (o_win_data),
        .o_win_row     (o_win_row)
    );

    always #5 i_clk = ~i_clk;

    // Reference image: pixel(row, col) = (row*IMG_W + col) mod 256.
    function automatic row_t row_pat(input int r);
        row_t v;
        for (int c = 0; c < IMG_W; c++) v[c] = pix_t'((r * IMG_W + c) % 256);
        return v;
    endfunction

    // Window r holds image rows r, r+1, r+2 with the oldest in slot 0.
    function automatic win_t exp_win(input int r);
        win_t w;
        for (int k = 0; k < K; k++) w[k] = row_pat(r + k);
        return w;
    endfunction

    // Memory: one-cycle read latency; non-read cycles return junk so stray captures show up.
    always @(posedge i_clk) begin
        if (o_mem_rd_en) i_mem_rd_data <= row_pat(int'(o_mem_rd_addr));
        else             i_mem_rd_data <= ~row_pat(int'(o_mem_rd_addr));
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int hs_idx = 0;
    int hs_cnt = 0;
    int exp_rd = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int first_vld_rel = -1;
    int done_rel = -1;
    int busy_lo_rel = -1;
    logic pv = 1'b0, pr = 1'b0, pa = 1'b0, prst = 1'b0;

    task automatic chk(input string tag, input logic [WINB-1:0] obs, input logic [WINB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; observe outputs 1 time unit after the edge and score them.
    task automatic tick();
        if (i_rstn && !i_abort && o_win_valid && i_win_ready) begin
            hs_idx++;
            hs_cnt++;
        end
        pv = o_win_valid; pr = i_win_ready; pa = i_abort; prst = i_rstn;
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_mem_rd_en) begin
            chk("rd_addr", WINB'(o_mem_rd_addr), WINB'(exp_rd));
            exp_rd++;
            rd_cnt++;
        end
        if (o_win_valid) begin
            if (first_vld_rel < 0) first_vld_rel = cyc - start_cyc;
            chk("win_row", WINB'(o_win_row), WINB'(hs_idx));
            chk("win_data", o_win_data, exp_win(hs_idx));
        end
        if (pv && !pr && !pa && prst && i_rstn) chk("valid_hold", WINB'(o_win_valid), WINB'(1));
        if (o_done) begin
            done_cnt++;
            if (done_rel < 0) done_rel = cyc - start_cyc;
        end
        if (!o_busy && busy_lo_rel < 0 && done_rel >= 0) busy_lo_rel = cyc - start_cyc;
    endtask

    task automatic start_frame();
        hs_idx = 0; hs_cnt = 0; exp_rd = 0; rd_cnt = 0; done_cnt = 0;
        first_vld_rel = -1; done_rel = -1; busy_lo_rel = -1;
        start_cyc = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"},  WINB'(o_busy),        '0);
        chk({tag, "_done"},  WINB'(o_done),        '0);
        chk({tag, "_rd_en"}, WINB'(o_mem_rd_en),   '0);
        chk({tag, "_addr"},  WINB'(o_mem_rd_addr), '0);
        chk({tag, "_valid"}, WINB'(o_win_valid),   '0);
        chk({tag, "_row"},   WINB'(o_win_row),     '0);
        chk({tag, "_data"},  o_win_data,           '0);
    endtask

    // mode 0: ready high; mode 1: random ready with 10-cycle stalls on windows 0 and 25;
    // mode 2: ready high with stray starts during window 7 and during DONE.
    task automatic run_frame(input int mode);
        int st = 0;
        int last_hs = -1;
        int guard = 0;
        int busy_gaps = 0;
        int idle_act = 0;
        start_frame();
        while (done_cnt == 0 && guard < 3000) begin
            if (!o_busy) busy_gaps++;
            if (mode == 1) begin
                if (hs_idx != last_hs) begin st = 0; last_hs = hs_idx; end
                if (o_win_valid && (hs_idx == 0 || hs_idx == 25) && st < 10) begin
                    i_win_ready = 1'b0;
                    st++;
                end else begin
                    i_win_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                i_win_ready = 1'b1;
            end
            i_start = (mode == 2) && o_win_valid && (hs_idx == 7);
            tick();
            guard++;
        end
        chk("frame_done_seen", WINB'(done_cnt), WINB'(1));
        i_start = (mode == 2);
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (o_busy || o_win_valid || o_mem_rd_en || o_done) idle_act++;
        end
        chk("frame_busy_gaps", WINB'(busy_gaps), '0);
        chk("frame_handshakes", WINB'(hs_cnt), WINB'(26));
        chk("frame_reads", WINB'(rd_cnt), WINB'(28));
        chk("frame_done_pulses", WINB'(done_cnt), WINB'(1));
        chk("frame_idle_after", WINB'(idle_act), '0);
        if (mode != 1) begin
            chk("first_valid_cycle", WINB'(first_vld_rel), WINB'(5));
            chk("done_cycle", WINB'(done_rel), WINB'(81));
            chk("busy_low_cycle", WINB'(busy_lo_rel), WINB'(82));
        end
    endtask

    initial begin
        int guard;

        // Power-up reset.
        i_rstn = 1'b0;
        repeat (3) tick();
        reset_checks("por");
        i_rstn = 1'b1;
        tick();

        // Full frames: ready high, random back-pressure, stray starts.
        run_frame(0);
        run_frame(1);
        run_frame(2);

        // Abort in WAIT before window 12, with its row read still returning.
        start_frame();
        i_win_ready = 1'b1;
        guard = 0;
        while (!(o_mem_rd_en && o_mem_rd_addr == AW'(14)) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_fetch12", WINB'(o_mem_rd_en), WINB'(1));
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort12_busy",  WINB'(o_busy),      '0);
        chk("abort12_valid", WINB'(o_win_valid), '0);
        chk("abort12_rd_en", WINB'(o_mem_rd_en), '0);
        chk("abort12_done",  WINB'(o_done),      '0);
        repeat (5) tick();
        chk("abort12_no_done", WINB'(done_cnt), '0);
        chk("abort12_hs", WINB'(hs_cnt), WINB'(12));
        chk("abort12_reads", WINB'(rd_cnt), WINB'(15));
        run_frame(0);

        // Reset for one cycle during PRIME (cycle 3).
        start_frame();
        i_win_ready = 1'b1;
        tick();
        tick();
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        reset_checks("prime_rst");
        run_frame(0);

        // Abort together with the handshake of the last window.
        start_frame();
        i_win_ready = 1'b1;
        guard = 0;
        while (!(o_win_valid && hs_idx == 25) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_win25", WINB'(o_win_valid), WINB'(1));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort25_busy",  WINB'(o_busy),      '0);
        chk("abort25_valid", WINB'(o_win_valid), '0);
        chk("abort25_done",  WINB'(o_done),      '0);
        repeat (5) tick();
        chk("abort25_no_done", WINB'(done_cnt), '0);
        chk("abort25_hs", WINB'(hs_cnt), WINB'(25));
        chk("abort25_idle", WINB'(o_busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
